// File: rtl/flit_demux_n.sv
`default_nettype none
// ============================================================================
// Module   : flit_demux_n
// Brief    : Wormhole flit demultiplexer with head-locked routing and a
//            one-entry registered output stage. Optional per-output transfer
//            counters are enabled by defining FLIT_DEMUX_STATS_EN.
// Revision : 1.0
// ============================================================================
module flit_demux_n #(
    parameter int FLIT_W  = 32,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FLIT_W-1:0]  in_flit,
    input  logic               in_head,
    input  logic               in_tail,
    input  logic [SEL_W-1:0]   in_select,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [FLIT_W-1:0]  out_flit,
    output logic               out_head,
    output logic               out_tail,
`ifdef FLIT_DEMUX_STATS_EN
    output logic [NUM_OUT*16-1:0] stat_count,
`endif
    output logic               err_drop
);

    localparam logic [SEL_W:0] c_num_out = (SEL_W+1)'(NUM_OUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BODY = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_buf_valid;
    logic [SEL_W-1:0]    r_buf_dest;
    logic [SEL_W-1:0]    r_lock_dest;
    logic [FLIT_W-1:0]   r_flit;
    logic                r_head;
    logic                r_tail;
    logic                r_err;

    logic [NUM_OUT-1:0]  w_dest_onehot;
    logic                w_ready_sel;
    logic                w_drain;
    logic                w_accept;
    logic                w_sel_ok;
    logic                w_load;
    logic                w_drop_err;
    logic [SEL_W-1:0]    w_load_dest;

    always_comb begin
        w_dest_onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            w_dest_onehot[i] = (r_buf_dest == SEL_W'(i));
        end
    end

    assign w_ready_sel = |(out_ready & w_dest_onehot);
    assign w_drain     = r_buf_valid & w_ready_sel;
    assign in_ready    = (r_state == S_DROP) | ~r_buf_valid | w_ready_sel;
    assign w_accept    = in_valid & in_ready;
    assign w_sel_ok    = ({1'b0, in_select} < c_num_out);

    // Routing decisions are only taken on an accepted flit.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop_err  = 1'b0;
        w_load_dest = r_lock_dest;
        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (in_head && w_sel_ok) begin
                        w_load      = 1'b1;
                        w_load_dest = in_select;
                        if (!in_tail) w_state_nxt = S_BODY;
                    end else begin
                        w_drop_err = 1'b1;
                        if (in_head && !in_tail) w_state_nxt = S_DROP;
                    end
                end
                S_BODY: begin
                    w_load = 1'b1;
                    if (in_tail) w_state_nxt = S_IDLE;
                end
                S_DROP: begin
                    if (in_tail) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_buf_valid <= 1'b0;
            r_buf_dest  <= '0;
            r_lock_dest <= '0;
            r_flit      <= '0;
            r_head      <= 1'b0;
            r_tail      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_drop_err;
            if (w_load) begin
                r_buf_valid <= 1'b1;
                r_buf_dest  <= w_load_dest;
                r_lock_dest <= w_load_dest;
                r_flit      <= in_flit;
                r_head      <= in_head;
                r_tail      <= in_tail;
            end else if (w_drain) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    assign out_valid = w_dest_onehot & {NUM_OUT{r_buf_valid}};
    assign out_flit  = r_flit;
    assign out_head  = r_head;
    assign out_tail  = r_tail;
    assign err_drop  = r_err;

`ifdef FLIT_DEMUX_STATS_EN
    for (genvar g = 0; g < NUM_OUT; g++) begin : g_stat
        logic [15:0] r_cnt;
        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (out_valid[g] && out_ready[g] && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
        assign stat_count[16*g +: 16] = r_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_flit_demux_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_flit_demux_n
// Brief    : Drives a 4-output and a 3-output demux with shared directed
//            stimulus and checks both against a packet-level queue model.
// Revision : 1.0
// ============================================================================
module tb_flit_demux_n;

    typedef struct {
        int          dest;
        logic [31:0] flit;
        logic        head;
        logic        tail;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_flit;
    logic        in_head;
    logic        in_tail;
    logic [1:0]  in_select;
    logic [3:0]  out_ready;

    logic        ir4, oh4, ot4, ed4;
    logic [3:0]  ov4;
    logic [31:0] of4;
    logic        ir3, oh3, ot3, ed3;
    logic [2:0]  ov3;
    logic [31:0] of3;
`ifdef FLIT_DEMUX_STATS_EN
    logic [63:0] sc4;
    logic [47:0] sc3;
`endif

    flit_demux_n #(.FLIT_W(32), .NUM_OUT(4), .SEL_W(2)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir4),
        .in_flit(in_flit), .in_head(in_head), .in_tail(in_tail),
        .in_select(in_select), .out_valid(ov4), .out_ready(out_ready),
        .out_flit(of4), .out_head(oh4), .out_tail(ot4),
`ifdef FLIT_DEMUX_STATS_EN
        .stat_count(sc4),
`endif
        .err_drop(ed4)
    );

    flit_demux_n #(.FLIT_W(32), .NUM_OUT(3), .SEL_W(2)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir3),
        .in_flit(in_flit), .in_head(in_head), .in_tail(in_tail),
        .in_select(in_select), .out_valid(ov3), .out_ready(out_ready[2:0]),
        .out_flit(of3), .out_head(oh3), .out_tail(ot3),
`ifdef FLIT_DEMUX_STATS_EN
        .stat_count(sc3),
`endif
        .err_drop(ed3)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 0;

    // Model: per instance, the flit waiting at the output (queue of at most
    // one), the packet mode (0 idle, 1 forwarding to lock, 2 dropping) and
    // whether an error pulse is due this cycle.
    exp_t mq [2][$];
    int   mode [2];
    int   lock [2];
    bit   err  [2];
    int   nout [2] = '{4, 3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        bit   pop, acc;
        exp_t e;
        pop = (mq[k].size() > 0) && out_ready[mq[k][0].dest];
        acc = in_valid && (mode[k] == 2 || mq[k].size() == 0 || pop);
        if (pop) void'(mq[k].pop_front());
        err[k] = 0;
        if (acc) begin
            e.flit = in_flit; e.head = in_head; e.tail = in_tail;
            if (mode[k] == 0) begin
                if (in_head && int'(in_select) < nout[k]) begin
                    e.dest = int'(in_select);
                    lock[k] = e.dest;
                    mq[k].push_back(e);
                    mode[k] = in_tail ? 0 : 1;
                end else begin
                    err[k] = 1;
                    if (in_head && !in_tail) mode[k] = 2;
                end
            end else if (mode[k] == 1) begin
                e.dest = lock[k];
                mq[k].push_back(e);
                if (in_tail) mode[k] = 0;
            end else if (in_tail) begin
                mode[k] = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (reset) begin
                    mq[k].delete();
                    mode[k] = 0;
                    err[k]  = 0;
                end else begin
                    model_step(k);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                for (int k = 0; k < 2; k++) begin
                    logic [3:0]  a_v, e_v;
                    logic [31:0] a_f;
                    logic        a_h, a_t, a_r, a_e, e_r;
                    a_v = (k == 0) ? ov4 : {1'b0, ov3};
                    a_f = (k == 0) ? of4 : of3;
                    a_h = (k == 0) ? oh4 : oh3;
                    a_t = (k == 0) ? ot4 : ot3;
                    a_r = (k == 0) ? ir4 : ir3;
                    a_e = (k == 0) ? ed4 : ed3;
                    e_v = '0;
                    e_r = (mode[k] == 2) || (mq[k].size() == 0);
                    if (mq[k].size() > 0) begin
                        e_v[mq[k][0].dest] = 1'b1;
                        e_r = e_r || out_ready[mq[k][0].dest];
                        chk($sformatf("m%0d.out_flit", k), a_f, mq[k][0].flit);
                        chk($sformatf("m%0d.out_head", k), a_h, mq[k][0].head);
                        chk($sformatf("m%0d.out_tail", k), a_t, mq[k][0].tail);
                    end
                    chk($sformatf("m%0d.out_valid", k), a_v, e_v);
                    chk($sformatf("m%0d.in_ready", k), a_r, e_r);
                    chk($sformatf("m%0d.err_drop", k), a_e, err[k]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic h, input logic t,
                         input logic [1:0] s, input logic [31:0] f);
        in_valid = v; in_head = h; in_tail = t; in_select = s; in_flit = f;
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 4'hF;
        drive(1, 1, 0, 2'd1, 32'hDEAD_BEEF);
        step();
        checking = 1;
        step();
        chk("rst.out_valid", ov4, 4'b0000);
        chk("rst.err_drop", ed4, 1'b0);
        chk("rst.out_flit", of4, 32'h0);
        chk("rst.out_headtail", {oh4, ot4}, 2'b00);
        reset = 1'b0;
        drive(0, 0, 0, 2'd0, 32'h0);
        #1;
        chk("rst.in_ready", ir4, 1'b1);

        // single-flit packet to output 2
        drive(1, 1, 1, 2'd2, 32'hA5A5_0001);
        step();
        drive(0, 0, 0, 2'd0, 32'h0);
        chk("single.out_valid", ov4, 4'b0100);
        chk("single.out_flit", of4, 32'hA5A5_0001);
        chk("single.headtail", {oh4, ot4}, 2'b11);
        step();
        chk("single.drained", ov4, 4'b0000);
        chk("single.hold_flit", of4, 32'hA5A5_0001);

        // 4-flit packet to output 1 with a 3-cycle stall after flit 2
        drive(1, 1, 0, 2'd1, 32'hB000_0000);
        step();
        drive(1, 0, 0, 2'd2, 32'hB000_0001);
        step();
        chk("pkt.flit2", of4, 32'hB000_0001);
        out_ready = 4'b1101;
        drive(1, 0, 0, 2'd3, 32'hB000_0002);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("pkt.stall_ready", ir4, 1'b0);
            step();
            chk("pkt.stall_valid", ov4, 4'b0010);
        end
        out_ready = 4'hF;
        step();
        chk("pkt.body_sel3", ov4, 4'b0010);
        chk("pkt.flit3", of4, 32'hB000_0002);
        drive(1, 0, 1, 2'd0, 32'hB000_0003);
        step();
        chk("pkt.tail", {of4, ot4}, {32'hB000_0003, 1'b1});
        drive(0, 0, 0, 2'd0, 32'h0);
        step();

        // select 3: routed on 4-output, dropped on 3-output
        drive(1, 1, 0, 2'd3, 32'hC000_0000);
        step();
        chk("sel3.err3", ed3, 1'b1);
        chk("sel3.ov3", {1'b0, ov3}, 4'b0000);
        chk("sel3.ov4", ov4, 4'b1000);
        drive(1, 0, 0, 2'd0, 32'hC000_0001);
        step();
        chk("sel3.err3_body", ed3, 1'b0);
        drive(1, 0, 1, 2'd0, 32'hC000_0002);
        step();
        chk("sel3.ov3_tail", {1'b0, ov3}, 4'b0000);
        drive(1, 1, 1, 2'd0, 32'hD000_0000);
        step();
        chk("sel3.next_ov3", {1'b0, ov3}, 4'b0001);
        chk("sel3.next_flit3", of3, 32'hD000_0000);

        // stray tail flit in idle
        drive(1, 0, 1, 2'd0, 32'hE000_0000);
        step();
        chk("stray.err", ed4, 1'b1);
        chk("stray.ov", ov4, 4'b0000);
        drive(0, 0, 0, 2'd0, 32'h0);
        step();
        chk("stray.err_clear", ed4, 1'b0);

        // reset in the middle of a packet to output 3
        drive(1, 1, 0, 2'd3, 32'hF000_0000);
        step();
        drive(1, 0, 0, 2'd0, 32'hF000_0001);
        step();
        drive(1, 0, 0, 2'd0, 32'hF000_0002);
        step();
        chk("midrst.pre", ov4, 4'b1000);
        reset = 1'b1;
        drive(0, 0, 0, 2'd0, 32'h0);
        step();
        chk("midrst.ov4", ov4, 4'b0000);
        chk("midrst.flit", of4, 32'h0);
        reset = 1'b0;
        drive(1, 1, 1, 2'd0, 32'h6000_0000);
        step();
        chk("midrst.ov4_next", ov4, 4'b0001);
        chk("midrst.ov3_next", {1'b0, ov3}, 4'b0001);
        chk("midrst.flit_next", of4, 32'h6000_0000);

        // mixed traffic with varying backpressure, checked by the model
        for (int i = 0; i < 40; i++) begin
            logic [3:0] rp;
            rp = 4'(i * 5) ^ 4'hA;
            out_ready = (i % 4 == 3) ? 4'hF : rp;
            drive(1, (i % 3) == 0, (i % 3) == 2, 2'(i / 3), 32'h7000_0000 + 32'(i));
            step();
        end
        drive(0, 0, 0, 2'd0, 32'h0);
        out_ready = 4'hF;
        step();
        step();
        checking = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
